dist_ascii_tx: RTL and testbench
================================

Name: dist_ascii_tx

Overview:
Upstream feeder for the UART TX stage in the distance-sensor design. It accepts one binary distance sample (mm) through a valid/ready handshake and converts it to fixed-width decimal ASCII by serial double-dabble. It then streams the frame "DDDDD\r\n" byte-by-byte into uart_tx over its data/en/busy interface. It replaces the free-running test counter that currently drives uart_tx_data.

Parameters:
DATA_W, 16, width of dist_data (unsigned binary).
DIGITS, 5, number of decimal digits emitted; must satisfy 10^DIGITS > 2^DATA_W - 1.
CRLF, 1, 1 appends 0x0D 0x0A after the digits; 0 emits digits only.

Ports:
clk  in  1  system clock (25 MHz).
rst  in  1  synchronous, active-high reset (from rst_gen).
dist_valid  in  1  sample present on dist_data.
dist_data  in  DATA_W  unsigned distance in mm.
dist_ready  out  1  block idle, able to accept a sample.
tx_data  out  8  byte to uart_tx (uart_tx_data).
tx_en  out  1  transmit request to uart_tx (uart_tx_en).
tx_busy  in  1  uart_tx_busy.
frame_done  out  1  one-cycle pulse when the last byte of a frame has finished transmitting.

Behaviour:
- Interface: one clock domain, clk. Reset rst is synchronous and active-high.
- Reset values:
  - dist_ready=0, tx_en=0, tx_data=0x00, frame_done=0.
  - State is IDLE. BCD register and byte index are cleared.
  - dist_ready reads 1 from the first clock edge after rst falls.
- Reset mid-frame: the frame is abandoned and tx_en drops on that edge. A byte already inside uart_tx completes on its own; no retransmission.
- States: IDLE, CONV, WAIT_FREE, REQ, WAIT_DONE, DONE.
- IDLE:
  - dist_ready=1.
  - On dist_valid & dist_ready, latch dist_data, clear the BCD register (4*DIGITS bits) and go to CONV.
  - dist_ready=0 in every other state. dist_valid outside IDLE is ignored; upstream holds the sample until accepted.
- CONV:
  - Runs exactly DATA_W cycles.
  - Each cycle: add 3 to every BCD nibble >=5, then shift {bcd, bin} left by 1.
  - After DATA_W cycles, set byte index=0 and go to WAIT_FREE.
- Byte order:
  - Digits go out most-significant first, as 0x30 + nibble. Leading zeros are always emitted.
  - With CRLF=1, 0x0D then 0x0A follow.
  - Frame length = DIGITS + 2*CRLF.
- WAIT_FREE:
  - tx_data = current byte.
  - Stay while tx_busy=1. When tx_busy=0, go to REQ.
- REQ:
  - tx_en=1 with tx_data stable.
  - Stay until tx_busy=1 is sampled; on that edge drop tx_en and go to WAIT_DONE.
  - tx_data must not change while tx_en=1.
- WAIT_DONE:
  - Stay while tx_busy=1.
  - When tx_busy=0: if the last byte was sent, go to DONE; otherwise increment the index and go to WAIT_FREE.
- DONE: frame_done=1 for exactly one cycle, then IDLE.
- Latency: the first tx_en rises DATA_W+2 cycles after the accept edge, provided tx_busy=0.
- Throughput: exactly one frame in flight. No input buffering.
- Input range: dist_data=0 gives all-'0' digits. The maximum 2^DATA_W-1 must convert exactly, with no overflow.

Test Plan:
- Model: the bench uart_tx raises busy one cycle after sampling en=1 and holds it for 10 cycles.
- Reset, then dist_data=1234 with valid -> bytes 0x30 0x31 0x32 0x33 0x34 0x0D 0x0A in order. Exactly one tx_en episode per byte. frame_done pulses once, then dist_ready=1.
- dist_data=0 -> "00000\r\n". dist_data=65535 -> "65535\r\n". Check the first tx_en at accept+18.
- tx_busy already high at frame start (held 50 cycles) -> tx_en stays 0 until busy falls, then the first byte is sent normally.
- dist_valid pulsed with 999 during the transmission of frame 42 -> 999 is ignored. The output is "00042\r\n" only, and dist_ready=0 throughout.
- rst asserted after the third byte's tx_en -> next edge: tx_en=0, dist_ready=0, no frame_done. After release, new sample 7 -> "00007\r\n".
- CRLF=0 build, dist_data=100 -> exactly 5 bytes "00100", with frame_done after the fifth byte's busy falls.

Source files
------------

// File: rtl/dist_ascii_tx.sv
// Converts one binary distance sample to fixed-width decimal ASCII by serial double-dabble
// and streams the frame (digits, optional CR LF) into uart_tx over its data/en/busy port.
module dist_ascii_tx #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DIGITS = 5,
   parameter int unsigned CRLF   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dist_valid,
   input  logic [DATA_W-1:0] dist_data,
   output logic              dist_ready,
   output logic [7:0]        tx_data,
   output logic              tx_en,
   input  logic              tx_busy,
   output logic              frame_done
);

   localparam int unsigned BCD_W     = 4 * DIGITS;
   localparam int unsigned FRAME_LEN = DIGITS + ((CRLF != 0) ? 2 : 0);
   localparam int unsigned IDX_W     = $clog2(FRAME_LEN + 1);
   localparam int unsigned CNT_W     = $clog2(DATA_W + 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(DATA_W);

   typedef enum logic [2:0] {
      StIdle,
      StConv,
      StWaitFree,
      StReq,
      StWaitDone,
      StDone
   } state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] bin_q, bin_d;
   logic [BCD_W-1:0]  bcd_q, bcd_d;
   logic [BCD_W-1:0]  bcd_adj;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [7:0]        byte_sel;
   logic              ready_q;
   logic              tx_en_q;
   logic [7:0]        tx_data_q;
   logic              frame_done_q;

   // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // Byte for the index being entered; digits most-significant first.
   always_comb begin
      byte_sel = 8'h0A;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_d == IDX_W'(i)) begin
            byte_sel = {4'h3, bcd_q[4*(DIGITS-1-i) +: 4]};
         end
      end
      if (CRLF != 0 && idx_d == IDX_W'(DIGITS)) begin
         byte_sel = 8'h0D;
      end
   end

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      unique case (state_q)
         StIdle: begin
            if (dist_valid && ready_q) begin
               bin_d   = dist_data;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = StConv;
            end
         end
         StConv: begin
            // The cycle after the last shift only hands over, so the BCD value is settled.
            if (cnt_q == CONV_LAST) begin
               idx_d   = '0;
               state_d = StWaitFree;
            end else begin
               {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
               cnt_d          = cnt_q + CNT_W'(1);
            end
         end
         StWaitFree: begin
            if (!tx_busy) begin
               state_d = StReq;
            end
         end
         StReq: begin
            if (tx_busy) begin
               state_d = StWaitDone;
            end
         end
         StWaitDone: begin
            if (!tx_busy) begin
               if (idx_q == LAST_IDX) begin
                  state_d = StDone;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = StWaitFree;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs are registered from the next state so uart_tx sees glitch-free levels.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         bin_q        <= '0;
         bcd_q        <= '0;
         cnt_q        <= '0;
         idx_q        <= '0;
         ready_q      <= 1'b0;
         tx_en_q      <= 1'b0;
         tx_data_q    <= 8'h00;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         bin_q        <= bin_d;
         bcd_q        <= bcd_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         ready_q      <= (state_d == StIdle);
         tx_en_q      <= (state_d == StReq);
         frame_done_q <= (state_d == StDone);
         if (state_d == StWaitFree) begin
            tx_data_q <= byte_sel;
         end
      end
   end

   assign dist_ready = ready_q;
   assign tx_en      = tx_en_q;
   assign tx_data    = tx_data_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_dist_ascii_tx.sv
// Randomized bench for dist_ascii_tx: a uart_tx model plus a frame-level reference model,
// compared against the DUT every cycle, with literal frames pinning the model.
module tb_dist_ascii_tx;

   localparam int DATA_W = 16;
   localparam int DIGITS = 5;
   localparam int FLEN   = 7;
   localparam int LAT    = DATA_W + 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        dist_valid = 1'b0;
   logic [15:0] dist_data = 16'h0;
   logic        dist_ready;
   logic [7:0]  tx_data;
   logic        tx_en;
   logic        tx_busy;
   logic        frame_done;
   logic        uart_busy = 1'b0;
   logic        busy_hold = 1'b0;

   logic        nc_valid = 1'b0;
   logic [15:0] nc_data = 16'h0;
   logic        nc_ready;
   logic [7:0]  nc_txd;
   logic        nc_en;
   logic        nc_busy = 1'b0;
   logic        nc_fd;

   always #5 clk = ~clk;
   assign tx_busy = uart_busy | busy_hold;

   dist_ascii_tx #(.DATA_W(16), .DIGITS(5), .CRLF(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .dist_valid (dist_valid),
      .dist_data  (dist_data),
      .dist_ready (dist_ready),
      .tx_data    (tx_data),
      .tx_en      (tx_en),
      .tx_busy    (tx_busy),
      .frame_done (frame_done)
   );

   dist_ascii_tx #(.DATA_W(16), .DIGITS(5), .CRLF(0)) dut_nc (
      .clk        (clk),
      .rst        (rst),
      .dist_valid (nc_valid),
      .dist_data  (nc_data),
      .dist_ready (nc_ready),
      .tx_data    (nc_txd),
      .tx_en      (nc_en),
      .tx_busy    (nc_busy),
      .frame_done (nc_fd)
   );

   int n_chk = 0;
   int n_pass = 0;

   // Reference model state (written only by the posedge model block).
   bit         pend = 1'b0;
   int         busy_cnt = 0;
   bit         exp_ready = 1'b0;
   bit         exp_fd = 1'b0;
   bit         fd_arm = 1'b0;
   bit         rst_seen = 1'b0;
   int         nbytes = 0;
   int         flush_to = 0;
   int         cyc = 0;
   logic [7:0] exp_q[$];

   // Monitor state (written only by the main initial block and its forked monitor).
   int         rd = 0;
   int         eps = 0;
   bit         prev_en = 1'b0;
   logic [7:0] held = 8'h0;
   logic [7:0] got[$];
   bit         chk_en = 1'b0;

   function automatic void check(string nm, int act, int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", nm, act, act, exp, exp);
   endfunction

   // Expected frame from plain decimal arithmetic.
   function automatic void push_frame(int unsigned v);
      logic [7:0] d [DIGITS];
      for (int k = DIGITS - 1; k >= 0; k--) begin
         d[k] = 8'h30 + 8'(v % 10);
         v    = v / 10;
      end
      for (int k = 0; k < DIGITS; k++) exp_q.push_back(d[k]);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endfunction

   // uart_tx model (busy one cycle after en is sampled, held 10 cycles) and frame model.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (pend) begin
         pend      <= 1'b0;
         uart_busy <= 1'b1;
         busy_cnt  <= 10;
      end else if (busy_cnt > 0) begin
         busy_cnt <= busy_cnt - 1;
         if (busy_cnt == 1) uart_busy <= 1'b0;
      end
      if (tx_en && !uart_busy && !pend && busy_cnt == 0) begin
         pend   <= 1'b1;
         nbytes <= nbytes + 1;
      end
      if (rst) begin
         exp_ready <= 1'b0;
         exp_fd    <= 1'b0;
         fd_arm    <= 1'b0;
         nbytes    <= 0;
         rst_seen  <= 1'b1;
         flush_to  <= exp_q.size();
      end else begin
         exp_fd <= fd_arm;
         fd_arm <= 1'b0;
         if (rst_seen) begin
            exp_ready <= 1'b1;
            rst_seen  <= 1'b0;
         end
         if (exp_fd) exp_ready <= 1'b1;
         if (exp_ready && dist_valid) begin
            exp_ready <= 1'b0;
            nbytes    <= 0;
            push_frame(32'(dist_data));
         end
         if (busy_cnt == 1 && nbytes == FLEN) fd_arm <= 1'b1;
      end
   end

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (rd < flush_to) rd = flush_to;
         if (chk_en) begin
            check("dist_ready", int'(dist_ready), int'(exp_ready));
            check("frame_done", int'(frame_done), int'(exp_fd));
            if (tx_en && !prev_en) begin
               eps++;
               got.push_back(tx_data);
               held = tx_data;
               check("byte_expected", int'(rd < exp_q.size()), 1);
               if (rd < exp_q.size()) begin
                  check("tx_byte", int'(tx_data), int'(exp_q[rd]));
                  rd++;
               end
            end else if (tx_en) begin
               check("tx_data_hold", int'(tx_data), int'(held));
            end
            if (frame_done) check("frame_all_sent", rd, exp_q.size());
         end
         prev_en = tx_en;
      end
   endtask

   task automatic nstep();
      @(negedge clk);
      #1;
   endtask

   task automatic start_frame();
      got.delete();
      eps = 0;
   endtask

   task automatic send(input int unsigned v, output int acc);
      bit ok = 1'b0;
      dist_valid = 1'b1;
      dist_data  = 16'(v);
      for (int i = 0; i < 1000 && !ok; i++) begin
         if (dist_ready) begin
            @(posedge clk);
            ok = 1'b1;
         end
         nstep();
      end
      acc        = cyc;
      dist_valid = 1'b0;
      check("accepted", int'(ok), 1);
   endtask

   task automatic check_latency(input int acc);
      int lat = -1;
      for (int i = 0; i < 100; i++) begin
         if (tx_en) begin
            lat = cyc - acc;
            break;
         end
         nstep();
      end
      check("first_tx_en_latency", lat, LAT);
   endtask

   task automatic wait_frame();
      bit seen = 1'b0;
      for (int i = 0; i < 800 && !seen; i++) begin
         nstep();
         if (frame_done) seen = 1'b1;
      end
      check("frame_done_seen", int'(seen), 1);
      nstep();
   endtask

   task automatic wait_eps(input int n);
      for (int i = 0; i < 400 && eps < n; i++) nstep();
      check("reached_byte", int'(eps >= n), 1);
   endtask

   task automatic check_str(input string nm, input string s);
      check({nm, "_len"}, got.size(), s.len());
      for (int i = 0; i < s.len() && i < got.size(); i++) check(nm, int'(got[i]), int'(s[i]));
   endtask

   task automatic run_nc();
      string s = "00100";
      bit    seen = 1'b0;
      int    extra = 0;
      nc_valid = 1'b1;
      nc_data  = 16'd100;
      for (int i = 0; i < 50 && !seen; i++) begin
         if (nc_ready) begin
            @(posedge clk);
            seen = 1'b1;
         end
         nstep();
      end
      nc_valid = 1'b0;
      check("nc_accepted", int'(seen), 1);
      for (int b = 0; b < 5; b++) begin
         seen = 1'b0;
         for (int i = 0; i < 200 && !seen; i++) begin
            nstep();
            if (nc_en) seen = 1'b1;
         end
         check("nc_en_seen", int'(seen), 1);
         check("nc_byte", int'(nc_txd), int'(s[b]));
         nstep();
         nc_busy = 1'b1;
         repeat (10) nstep();
         nc_busy = 1'b0;
         nstep();
         check("nc_frame_done", int'(nc_fd), (b == 4) ? 1 : 0);
      end
      for (int i = 0; i < 40; i++) begin
         nstep();
         if (nc_en || nc_fd) extra++;
      end
      check("nc_no_extra", extra, 0);
      check("nc_ready_after", int'(nc_ready), 1);
   endtask

   initial begin
      int acc;
      int hi;
      fork
         monitor();
      join_none
      repeat (3) nstep();
      chk_en = 1'b1;
      check("rst_dist_ready", int'(dist_ready), 0);
      check("rst_tx_en", int'(tx_en), 0);
      check("rst_tx_data", int'(tx_data), 0);
      check("rst_frame_done", int'(frame_done), 0);
      rst = 1'b0;
      nstep();
      check("ready_after_rst", int'(dist_ready), 1);

      start_frame();
      send(1234, acc);
      wait_frame();
      check_str("frame_1234", "01234\r\n");
      check("episodes_1234", eps, FLEN);
      check("ready_after_frame", int'(dist_ready), 1);

      start_frame();
      send(0, acc);
      check_latency(acc);
      wait_frame();
      check_str("frame_0", "00000\r\n");

      start_frame();
      send(65535, acc);
      check_latency(acc);
      wait_frame();
      check_str("frame_max", "65535\r\n");

      // Busy already high when the frame starts.
      busy_hold = 1'b1;
      start_frame();
      send($urandom_range(0, 65535), acc);
      hi = 0;
      for (int i = 0; i < 50; i++) begin
         nstep();
         if (tx_en) hi++;
      end
      busy_hold = 1'b0;
      check("en_while_busy", hi, 0);
      wait_frame();
      check("episodes_busy", eps, FLEN);

      // Sample offered mid-frame must be ignored.
      start_frame();
      send(42, acc);
      wait_eps(2);
      dist_valid = 1'b1;
      dist_data  = 16'd999;
      nstep();
      dist_valid = 1'b0;
      wait_frame();
      check_str("frame_42", "00042\r\n");

      // Reset right after the third byte's request.
      start_frame();
      send($urandom_range(0, 65535), acc);
      wait_eps(3);
      rst = 1'b1;
      nstep();
      check("midrst_tx_en", int'(tx_en), 0);
      check("midrst_ready", int'(dist_ready), 0);
      check("midrst_frame_done", int'(frame_done), 0);
      nstep();
      rst = 1'b0;
      nstep();
      check("ready_after_midrst", int'(dist_ready), 1);
      start_frame();
      send(7, acc);
      wait_frame();
      check_str("frame_7", "00007\r\n");

      for (int f = 0; f < 6; f++) begin
         repeat ($urandom_range(0, 4)) nstep();
         start_frame();
         send($urandom_range(0, 65535), acc);
         if ($urandom_range(0, 1) == 1) begin
            wait_eps(1 + $urandom_range(0, 5));
            dist_valid = 1'b1;
            dist_data  = 16'($urandom);
            nstep();
            dist_valid = 1'b0;
         end
         wait_frame();
         check("episodes_rand", eps, FLEN);
      end

      run_nc();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1);
   end

endmodule
